combo_lock_ctrl: RTL
====================

Name: combo_lock_ctrl

Overview:
Sequencer for the combination lock. It takes debounced key presses, keeps a count of entered digits (0..DIGITS, the same role as the count-to-4 digit counter), and stores each entered digit in a shift register. After the last digit it compares the entry against the stored code and drives unlock, error and lockout status. It sits between the debounced keypad/switch inputs and the LED/display and latch outputs.

Parameters:
DIGITS, 4, digits per combination (2..7; must fit the 3-bit count)
DIGIT_W, 4, bits per digit
RESET_CODE, 16'h1234, code loaded at reset; DIGITS*DIGIT_W bits; first digit in the MSBs
OPEN_CYCLES, 8, cycles unlocked stays high
MAX_FAILS, 3, consecutive failures that trigger lockout
LOCKOUT_CYCLES, 16, lockout duration in cycles

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
trig  in  1  debounced key-press level; each rising edge enters one digit
digit  in  DIGIT_W  digit value, sampled on the cycle the trig edge is detected
clr  in  1  synchronous abort of the current entry
count  out  3  digits entered so far
unlocked  out  1  high while in OPEN
err  out  1  one-cycle pulse on a mismatch
lockout  out  1  high while in LOCKOUT
busy  out  1  high in ENTRY or CHECK

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; count=0; unlocked=0; err=0; lockout=0; busy=0.
  - fail counter=0; entry register=0; code register=RESET_CODE; trig edge register=0.
- Edge detect:
  - press = trig & ~trig_q, where trig_q is trig delayed one clock.
  - A held trig counts once.
- States:
  - IDLE: a press shifts digit into the entry register (new digit enters the LSBs), sets count=1 and goes to ENTRY.
  - ENTRY:
    - Each press shifts digit in and increments count.
    - The press that makes count==DIGITS goes to CHECK.
    - clr: count=0, entry=0, go to IDLE (fail counter unchanged).
  - CHECK (one cycle; presses ignored):
    - entry==code: go to OPEN, reset the fail counter, start the OPEN_CYCLES timer.
    - Otherwise: err=1 for this cycle only and the fail counter increments.
      - If the fail counter reaches MAX_FAILS: go to LOCKOUT, start the LOCKOUT_CYCLES timer, reset the fail counter.
      - Else: go to IDLE.
    - count returns to 0 on leaving CHECK.
  - OPEN:
    - unlocked=1 for exactly OPEN_CYCLES cycles, then IDLE.
    - Presses are ignored.
    - clr ends OPEN early (go to IDLE next cycle).
  - LOCKOUT:
    - lockout=1 for exactly LOCKOUT_CYCLES cycles, then IDLE.
    - Presses and clr are ignored.
- Latency:
  - The last-digit press is detected at edge N; CHECK runs in cycle N+1.
  - unlocked or err is visible after edge N+1 (registered outputs).
- Simultaneous events:
  - clr beats a press in the same cycle.
  - A press in the cycle that leaves OPEN or LOCKOUT is dropped.
- Counter limits:
  - count never exceeds DIGITS and never wraps.
  - The fail counter saturates at MAX_FAILS.
  - Timers are sized by $clog2 of the cycle count and load N-1.
- Reset mid-entry or mid-lockout returns everything to the reset values immediately.

Optional Feature:
Macro: COMBO_LOCK_PROG_EN
- Defined:
  - Adds input port prog (1 bit).
  - prog=1 during OPEN enters PROG state: unlocked stays 1 and the OPEN timer is frozen.
  - In PROG, DIGITS presses are shifted into the code register. Before committing, the new value is staged; count is shown as usual.
  - After the last press, the code register is updated and the state goes to IDLE.
  - clr in PROG discards the staged code.
  - Reset restores RESET_CODE.
- Not defined:
  - No prog port; the code register is the constant RESET_CODE.

Test Plan:
- Reset, then press 1,2,3,4 (one clock per trig pulse) -> count steps 1,2,3,4; unlocked=1 one cycle after CHECK for exactly 8 cycles; err never set.
- Press 1,2,3,5 -> err pulses for one cycle; count=0; unlocked stays 0; the next 1,2,3,4 opens the lock.
- Three consecutive wrong codes -> on the third CHECK, lockout=1 for 16 cycles; a correct code pressed during lockout is ignored; after lockout the correct code opens.
- trig held high for 10 cycles with digit=1 -> count=1 only; press 2, clr, then 1,2,3,4 -> opens (clr cleared the partial entry).
- Drop rst_n to 0 mid-entry at count=2 and mid-lockout -> all outputs go to 0 immediately, before the next clk edge; the fail counter is cleared.
- With COMBO_LOCK_PROG_EN: open with 1,2,3,4, assert prog, press 9,8,7,6 -> 1,2,3,4 now gives err and 9,8,7,6 opens.

Source files
------------

// File: rtl/combo_lock_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : combo_lock_ctrl_if
// Purpose  : Keypad-side inputs and status outputs of the combination lock
//            sequencer. The prog signal exists only with COMBO_LOCK_PROG_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface combo_lock_ctrl_if #(
   parameter int DIGIT_W = 4
) ();
   logic               trig;
   logic [DIGIT_W-1:0] digit;
   logic               clr;
`ifdef COMBO_LOCK_PROG_EN
   logic               prog;
`endif
   logic [2:0]         count;
   logic               unlocked;
   logic               err;
   logic               lockout;
   logic               busy;

`ifdef COMBO_LOCK_PROG_EN
   modport master (output trig, digit, clr, prog,
                   input  count, unlocked, err, lockout, busy);
   modport slave  (input  trig, digit, clr, prog,
                   output count, unlocked, err, lockout, busy);
`else
   modport master (output trig, digit, clr,
                   input  count, unlocked, err, lockout, busy);
   modport slave  (input  trig, digit, clr,
                   output count, unlocked, err, lockout, busy);
`endif
endinterface
`default_nettype wire

// File: rtl/combo_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : combo_lock_ctrl
// Purpose  : Combination lock sequencer: digit entry, code check, open timer,
//            failure counting and lockout. COMBO_LOCK_PROG_EN adds code programming.
// Revision : 1.0 - initial release
// ============================================================================
module combo_lock_ctrl #(
   parameter int                        DIGITS         = 4,
   parameter int                        DIGIT_W        = 4,
   parameter logic [DIGITS*DIGIT_W-1:0] RESET_CODE     = 16'h1234,
   parameter int                        OPEN_CYCLES    = 8,
   parameter int                        MAX_FAILS      = 3,
   parameter int                        LOCKOUT_CYCLES = 16
) (
   input wire logic         clk,
   input wire logic         rst_n,
   combo_lock_ctrl_if.slave bus
);
   localparam int c_code_w  = DIGITS * DIGIT_W;
   localparam int c_fail_w  = $clog2(MAX_FAILS + 1);
   localparam int c_open_w  = $clog2(OPEN_CYCLES);
   localparam int c_lock_w  = $clog2(LOCKOUT_CYCLES);
   localparam int c_tmr_raw = (c_open_w > c_lock_w) ? c_open_w : c_lock_w;
   localparam int c_tmr_w   = (c_tmr_raw < 1) ? 1 : c_tmr_raw;

   localparam logic [2:0]          c_last    = 3'(DIGITS - 1);
   localparam logic [c_fail_w-1:0] c_max_f   = c_fail_w'(MAX_FAILS);
   localparam logic [c_tmr_w-1:0]  c_open_ld = c_tmr_w'(OPEN_CYCLES - 1);
   localparam logic [c_tmr_w-1:0]  c_lock_ld = c_tmr_w'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_CHECK   = 3'd2,
      S_OPEN    = 3'd3,
      S_LOCKOUT = 3'd4,
      S_PROG    = 3'd5
   } state_t;

   state_t                r_state, w_state_nx;
   logic                  r_trig_q;
   logic                  w_press;
   logic [2:0]            r_count, w_count_nx;
   logic [c_code_w-1:0]   r_entry, w_entry_nx, w_shift, w_code;
   logic [c_fail_w-1:0]   r_fails, w_fails_nx, w_fails_inc;
   logic [c_tmr_w-1:0]    r_tmr, w_tmr_nx;
   logic                  r_err, w_err_nx;

`ifdef COMBO_LOCK_PROG_EN
   logic [c_code_w-1:0]   r_code, w_code_nx;
   assign w_code = r_code;
`else
   assign w_code = RESET_CODE;
`endif

   assign w_press     = bus.trig & ~r_trig_q;
   assign w_shift     = {r_entry[c_code_w-DIGIT_W-1:0], bus.digit};
   assign w_fails_inc = r_fails + c_fail_w'(1);

   always_comb begin
      w_state_nx = r_state;
      w_count_nx = r_count;
      w_entry_nx = r_entry;
      w_fails_nx = r_fails;
      w_tmr_nx   = r_tmr;
      w_err_nx   = 1'b0;
`ifdef COMBO_LOCK_PROG_EN
      w_code_nx  = r_code;
`endif
      case (r_state)
         S_IDLE: begin
            if (!bus.clr && w_press) begin
               w_entry_nx = w_shift;
               w_count_nx = 3'd1;
               w_state_nx = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (bus.clr) begin
               w_count_nx = 3'd0;
               w_entry_nx = '0;
               w_state_nx = S_IDLE;
            end else if (w_press) begin
               w_entry_nx = w_shift;
               w_count_nx = r_count + 3'd1;
               if (r_count == c_last) w_state_nx = S_CHECK;
            end
         end
         S_CHECK: begin
            w_count_nx = 3'd0;
            w_entry_nx = '0;
            if (r_entry == w_code) begin
               w_fails_nx = '0;
               w_tmr_nx   = c_open_ld;
               w_state_nx = S_OPEN;
            end else begin
               w_err_nx = 1'b1;
               // fails never exceeds MAX_FAILS-1 here, so the increment cannot overflow
               if (w_fails_inc == c_max_f) begin
                  w_fails_nx = '0;
                  w_tmr_nx   = c_lock_ld;
                  w_state_nx = S_LOCKOUT;
               end else begin
                  w_fails_nx = w_fails_inc;
                  w_state_nx = S_IDLE;
               end
            end
         end
         S_OPEN: begin
            if (bus.clr) begin
               w_state_nx = S_IDLE;
`ifdef COMBO_LOCK_PROG_EN
            end else if (bus.prog) begin
               w_state_nx = S_PROG;
`endif
            end else if (r_tmr == '0) begin
               w_state_nx = S_IDLE;
            end else begin
               w_tmr_nx = r_tmr - c_tmr_w'(1);
            end
         end
         S_LOCKOUT: begin
            if (r_tmr == '0) w_state_nx = S_IDLE;
            else             w_tmr_nx   = r_tmr - c_tmr_w'(1);
         end
`ifdef COMBO_LOCK_PROG_EN
         S_PROG: begin
            // entry register doubles as the staging buffer for the new code
            if (bus.clr) begin
               w_count_nx = 3'd0;
               w_entry_nx = '0;
               w_state_nx = S_IDLE;
            end else if (w_press) begin
               w_entry_nx = w_shift;
               w_count_nx = r_count + 3'd1;
               if (r_count == c_last) begin
                  w_code_nx  = w_shift;
                  w_entry_nx = '0;
                  w_count_nx = 3'd0;
                  w_state_nx = S_IDLE;
               end
            end
         end
`endif
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_trig_q <= 1'b0;
         r_count  <= 3'd0;
         r_entry  <= '0;
         r_fails  <= '0;
         r_tmr    <= '0;
         r_err    <= 1'b0;
`ifdef COMBO_LOCK_PROG_EN
         r_code   <= RESET_CODE;
`endif
      end else begin
         r_state  <= w_state_nx;
         r_trig_q <= bus.trig;
         r_count  <= w_count_nx;
         r_entry  <= w_entry_nx;
         r_fails  <= w_fails_nx;
         r_tmr    <= w_tmr_nx;
         r_err    <= w_err_nx;
`ifdef COMBO_LOCK_PROG_EN
         r_code   <= w_code_nx;
`endif
      end
   end

   assign bus.count    = r_count;
   assign bus.err      = r_err;
   assign bus.unlocked = (r_state == S_OPEN) || (r_state == S_PROG);
   assign bus.lockout  = (r_state == S_LOCKOUT);
   assign bus.busy     = (r_state == S_ENTRY) || (r_state == S_CHECK);
endmodule
`default_nettype wire
